// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: PC inputs, instruction-memory bus, decode handshake and IF/ID outputs.
// master is the fetch unit; slave is the surrounding pipeline/memory side.
interface fetch_unit_if;
    logic [31:0] imemaddr;
    logic [31:0] pc_plus_4;
    logic [31:0] iaddr;
    logic        iREN;
    logic        ihit;
    logic [31:0] iload;
    logic        dmem_req;
    logic        stall;
    logic        flush;
    logic        pc_en;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic        valid_out;
    logic        halt;
    logic [1:0]  state_dbg;

    // Handshake: a word is accepted only when iREN and ihit are both high in the same cycle;
    // ihit while iREN is low carries no meaning. stall high means decode refuses a new word.
    modport master (
        input  imemaddr, pc_plus_4, ihit, iload, dmem_req, stall, flush,
        output iaddr, iREN, pc_en, instr_out, pc4_out, valid_out, halt, state_dbg
    );

    modport slave (
        output imemaddr, pc_plus_4, ihit, iload, dmem_req, stall, flush,
        input  iaddr, iREN, pc_en, instr_out, pc4_out, valid_out, halt, state_dbg
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem reads, fills IF/ID, absorbs decode stalls in a one-entry skid.
// Optional FETCH_HALT_EN: opcode 6'h3F entering IF/ID parks the stage in HALTED until reset.
module fetch_unit #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic          CLK,
    input logic          nRST,
    fetch_unit_if.master fu
);
    localparam logic [1:0] FETCH    = 2'd0;
    localparam logic [1:0] BUFFERED = 2'd1;
    localparam logic [1:0] HALTED   = 2'd2;

    logic [1:0]  state, next_state;
    logic [31:0] instr_r, instr_n;
    logic [31:0] pc4_r, pc4_n;
    logic        valid_r, valid_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_pc4, skid_pc4_n;
    logic        acc;

    assign fu.iaddr     = fu.imemaddr;
    assign fu.iREN      = (state == FETCH) && !fu.dmem_req;
    assign acc          = fu.iREN && fu.ihit;
    // Flush redirects the PC even from BUFFERED; a stalled accept still advances since the skid holds it.
    assign fu.pc_en     = (state != HALTED) && (fu.flush || acc);
    assign fu.instr_out = instr_r;
    assign fu.pc4_out   = pc4_r;
    assign fu.valid_out = valid_r;
    assign fu.state_dbg = state;

`ifdef FETCH_HALT_EN
    assign fu.halt = (state == HALTED);
`else
    assign fu.halt = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        instr_n      = instr_r;
        pc4_n        = pc4_r;
        valid_n      = valid_r;
        skid_instr_n = skid_instr;
        skid_pc4_n   = skid_pc4;
        case (state)
            FETCH, BUFFERED: begin
                if (fu.flush) begin
                    instr_n      = NOP_WORD;
                    pc4_n        = 32'h0;
                    valid_n      = 1'b0;
                    skid_instr_n = 32'h0;
                    skid_pc4_n   = 32'h0;
                    next_state   = FETCH;
                end else if (state == BUFFERED) begin
                    if (!fu.stall) begin
                        instr_n    = skid_instr;
                        pc4_n      = skid_pc4;
                        valid_n    = 1'b1;
                        next_state = FETCH;
`ifdef FETCH_HALT_EN
                        if (skid_instr[31:26] == 6'h3F) next_state = HALTED;
`endif
                    end
                end else if (fu.stall) begin
                    if (acc) begin
                        skid_instr_n = fu.iload;
                        skid_pc4_n   = fu.pc_plus_4;
                        next_state   = BUFFERED;
                    end
                end else if (acc) begin
                    instr_n = fu.iload;
                    pc4_n   = fu.pc_plus_4;
                    valid_n = 1'b1;
`ifdef FETCH_HALT_EN
                    if (fu.iload[31:26] == 6'h3F) next_state = HALTED;
`endif
                end else begin
                    instr_n = NOP_WORD;
                    pc4_n   = 32'h0;
                    valid_n = 1'b0;
                end
            end
            HALTED: begin
            end
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            instr_r    <= NOP_WORD;
            pc4_r      <= 32'h0;
            valid_r    <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc4   <= 32'h0;
        end else begin
            state      <= next_state;
            instr_r    <= instr_n;
            pc4_r      <= pc4_n;
            valid_r    <= valid_n;
            skid_instr <= skid_instr_n;
            skid_pc4   <= skid_pc4_n;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cases, a random accept/stall/dmem phase and a scoreboard.
// Honours FETCH_HALT_EN when the same define is given to the bench.
module tb_fetch_unit;
    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];
    logic        prev_valid = 1'b0;
    logic [63:0] prev_word = 64'h0;

    fetch_unit_if fif();

    fetch_unit #(.NOP_WORD(32'h0000_0000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fu   (fif)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // driver: inputs change 1 time unit after the rising edge, combinational outputs checked at +2
    task automatic drive(input logic h, input logic [31:0] w, input logic [31:0] p4,
                         input logic st, input logic fl, input logic dm);
        @(posedge CLK);
        #1;
        fif.ihit      = h;
        fif.iload     = w;
        fif.pc_plus_4 = p4;
        fif.imemaddr  = p4 - 32'd4;
        fif.stall     = st;
        fif.flush     = fl;
        fif.dmem_req  = dm;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_comb(input string tag, input logic ren, input logic pcen);
        check({tag, "_iREN"}, 64'(fif.iREN), 64'(ren));
        check({tag, "_pc_en"}, 64'(fif.pc_en), 64'(pcen));
    endtask

    // scoreboard: a new IF/ID word (valid, and different from last cycle) must match the queue head
    always @(negedge CLK) begin
        if (!nRST) begin
            prev_valid <= 1'b0;
        end else begin
            if (fif.valid_out && (!prev_valid || {fif.instr_out, fif.pc4_out} != prev_word)) begin
                if (exp_q.size() == 0) check("sb_extra", 64'(fif.valid_out), 64'd0);
                else check("sb_word", {fif.instr_out, fif.pc4_out}, exp_q.pop_front());
            end
            prev_valid <= fif.valid_out;
            prev_word  <= {fif.instr_out, fif.pc4_out};
        end
    end

    initial begin
        logic tb_buf;
        logic h, st, dm, acc;
        logic [31:0] w, p4;

        nRST = 1'b0;
        fif.ihit = 1'b0; fif.iload = 32'h0; fif.pc_plus_4 = 32'h0; fif.imemaddr = 32'h0;
        fif.stall = 1'b0; fif.flush = 1'b0; fif.dmem_req = 1'b0;
        #2;
        check("rst_instr", 64'(fif.instr_out), 64'h0);
        check("rst_pc4", 64'(fif.pc4_out), 64'h0);
        check("rst_valid", 64'(fif.valid_out), 64'd0);
        check("rst_halt", 64'(fif.halt), 64'd0);
        check("rst_state", 64'(fif.state_dbg), 64'd0);
        check_comb("rst", 1'b1, 1'b0);
        fif.flush = 1'b1;
        #1;
        check("rst_flush_pc_en", 64'(fif.pc_en), 64'd1);
        fif.flush = 1'b0;
        #5;
        nRST = 1'b1;

        // basic fetch
        drive(1'b1, 32'h2008_0005, 32'h4, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({32'h2008_0005, 32'h4});
        check_comb("fetch", 1'b1, 1'b1);
        check("iaddr", 64'(fif.iaddr), 64'h0);
        idle();
        check_comb("idle", 1'b1, 1'b0);
        check("fetch_instr", 64'(fif.instr_out), 64'h2008_0005);
        check("fetch_pc4", 64'(fif.pc4_out), 64'h4);
        check("fetch_valid", 64'(fif.valid_out), 64'd1);

        // stall with skid
        drive(1'b1, 32'hAAAA_0001, 32'h8, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({32'hAAAA_0001, 32'h8});
        check_comb("skid_acc", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h5555_0000, 32'hC, 1'b1, 1'b0, 1'b0);
            check_comb("skid_hold", 1'b0, 1'b0);
            check("skid_state", 64'(fif.state_dbg), 64'd1);
            check("skid_instr", 64'(fif.instr_out), 64'h0);
        end
        drive(1'b1, 32'h5555_0000, 32'hC, 1'b0, 1'b0, 1'b0);
        check_comb("skid_release", 1'b0, 1'b0);

        // flush coincident with hit
        drive(1'b1, 32'h1234_5678, 32'hC, 1'b0, 1'b1, 1'b0);
        check("skid_delivered", 64'(fif.instr_out), 64'hAAAA_0001);
        check_comb("flush_hit", 1'b1, 1'b1);
        idle();
        check("flush_valid", 64'(fif.valid_out), 64'd0);
        check("flush_instr", 64'(fif.instr_out), 64'h0);

        // flush while buffered
        drive(1'b1, 32'hBBBB_0002, 32'h10, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h10, 1'b1, 1'b1, 1'b0);
        check_comb("flush_buf", 1'b0, 1'b1);
        drive(1'b1, 32'hCCCC_0003, 32'h14, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({32'hCCCC_0003, 32'h14});
        check("flush_buf_state", 64'(fif.state_dbg), 64'd0);
        check("flush_buf_valid", 64'(fif.valid_out), 64'd0);
        check_comb("after_flush", 1'b1, 1'b1);
        idle();
        check("after_flush_instr", 64'(fif.instr_out), 64'hCCCC_0003);

        // data-memory contention
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hDDDD_0004, 32'h18, 1'b0, 1'b0, 1'b1);
            check_comb("dmem", 1'b0, 1'b0);
        end
        drive(1'b1, 32'hEEEE_0005, 32'h18, 1'b0, 1'b0, 1'b0);
        check("dmem_bubble", 64'(fif.valid_out), 64'd0);
        check_comb("dmem_resume", 1'b1, 1'b1);
        exp_q.push_back({32'hEEEE_0005, 32'h18});
        idle();

        // reset while buffered: skid contents lost
        drive(1'b1, 32'h9999_0009, 32'h200, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h200, 1'b1, 1'b0, 1'b0);
        check("pre_rst_state", 64'(fif.state_dbg), 64'd1);
        #1 nRST = 1'b0;
        #1;
        check("mid_rst_state", 64'(fif.state_dbg), 64'd0);
        check("mid_rst_valid", 64'(fif.valid_out), 64'd0);
        #2 nRST = 1'b1;
        for (int i = 0; i < 3; i++) idle();
        check("post_rst_valid", 64'(fif.valid_out), 64'd0);

        // random accept / stall / dmem traffic
        tb_buf = 1'b0;
        for (int i = 0; i < 300; i++) begin
            h  = ($urandom_range(0, 99) < 70);
            st = ($urandom_range(0, 99) < 30);
            dm = ($urandom_range(0, 99) < 20);
            w  = 32'h1000_0000 | 32'(i);
            p4 = 32'h1000 + 32'(i) * 32'd4;
            drive(h, w, p4, st, 1'b0, dm);
            acc = !tb_buf && !dm && h;
            check_comb("rand", !tb_buf && !dm, acc);
            if (tb_buf) begin
                if (!st) tb_buf = 1'b0;
            end else if (acc) begin
                exp_q.push_back({w, p4});
                if (st) tb_buf = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) idle();
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        // halt opcode
        drive(1'b1, 32'hFC00_0000, 32'h300, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({32'hFC00_0000, 32'h300});
        check_comb("halt_fetch", 1'b1, 1'b1);
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h1111_0000 | 32'(i), 32'h304, 1'b0, (i == 5), 1'b0);
            check_comb("halted", 1'b0, 1'b0);
            check("halted_halt", 64'(fif.halt), 64'd1);
            check("halted_valid", 64'(fif.valid_out), 64'd1);
            check("halted_instr", 64'(fif.instr_out), 64'hFC00_0000);
        end
`else
        drive(1'b1, 32'h1111_0001, 32'h304, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({32'h1111_0001, 32'h304});
        check_comb("nohalt_fetch", 1'b1, 1'b1);
        check("nohalt_halt", 64'(fif.halt), 64'd0);
        idle();
        check("nohalt_halt2", 64'(fif.halt), 64'd0);
        idle();
`endif
        idle();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage between the program counter and decode. It drives the instruction-memory read for the current PC and captures the returned word into the IF/ID pipeline register. It generates the PC's advance enable (`pc_en`) and absorbs decode stalls with a one-entry skid buffer. Branch/jump flushes and data-memory contention are handled here so the PC block only sees a single qualified enable.

## Interface
Parameters:
- `NOP_WORD`, 32'h0000_0000, value loaded into `instr_out` on reset, flush and bubble.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `imemaddr`  in  32  current PC from program counter.
- `pc_plus_4`  in  32  PC+4 from program counter.
- `iaddr`  out  32  instruction memory address; equals `imemaddr` combinationally.
- `iREN`  out  1  instruction read request.
- `ihit`  in  1  instruction memory returned `iload` this cycle.
- `iload`  in  32  instruction word from memory.
- `dmem_req`  in  1  data access in flight; memory port is busy.
- `stall`  in  1  decode cannot accept a new instruction.
- `flush`  in  1  branch/jump resolved taken; discard younger instructions.
- `pc_en`  out  1  PC advance enable (combinational).
- `instr_out`  out  32  IF/ID instruction.
- `pc4_out`  out  32  IF/ID PC+4.
- `valid_out`  out  1  IF/ID holds a real instruction.
- `halt`  out  1  fetch halted (see Configuration).

## Operation
- States: FETCH, BUFFERED, HALTED. Reset state is FETCH.
- Accept condition: `acc = iREN & ihit`. `ihit` is ignored whenever `iREN`=0.

FETCH:
- `iREN = !dmem_req`.
- `acc & !stall`: IF/ID ← {`iload`, `pc_plus_4`, valid=1}; `pc_en`=1.
- `acc & stall`: skid ← {`iload`, `pc_plus_4`}; `pc_en`=1; IF/ID unchanged; next state BUFFERED.
- `!acc & !stall`: IF/ID ← bubble {`NOP_WORD`, 0, valid=0}.
- `!acc & stall`: IF/ID holds.

BUFFERED:
- `iREN`=0 and `pc_en`=0.
- If `stall`=0: IF/ID ← skid with valid=1; next state FETCH.
- Otherwise hold.

Flush (any state except HALTED):
- Highest priority.
- IF/ID ← bubble; skid discarded; next state FETCH.
- `pc_en`=1, so the PC loads the redirect target.
- Any `acc` in the same cycle is discarded.

Priority: `flush` > `stall` > `acc`.

HALTED:
- `iREN`=0, `pc_en`=0, `halt`=1.
- IF/ID holds its contents.
- Exited only by reset.

## Timing
- `iaddr`, `iREN` and `pc_en` are combinational from state and inputs. There is no registered path from `ihit` to `pc_en`.
- IF/ID and skid registers update on the rising edge of `CLK`.
- Latency: instruction visible on `instr_out` the cycle after `acc` (no stall).
- Reset values: `instr_out`=`NOP_WORD`, `pc4_out`=0, `valid_out`=0, `halt`=0, skid=0, state=FETCH. Combinational outputs settle to `iREN`=!`dmem_req`, `pc_en`=`flush`.
- Reset asserted mid-BUFFERED: the skid contents are lost and no instruction is delivered.
- `dmem_req` rising while a fetch is pending: `iREN` drops that cycle. A concurrent `ihit` is ignored and the same PC is re-requested.
- Stall held for N cycles in BUFFERED: exactly one instruction is delivered after release. No duplicates and no drops.

## Configuration
- `FETCH_HALT_EN` defined:
  - When a word with `iload[31:26]`=6'h3F is written into IF/ID (directly or from skid) and `flush`=0 that cycle, the next state is HALTED and `halt` rises the following cycle.
  - The halt instruction itself is delivered with valid=1.
- `FETCH_HALT_EN` undefined:
  - `halt` is tied 0.
  - HALTED is unreachable.
  - Opcode 6'h3F is fetched like any other instruction.

## Test plan
- Reset, then `ihit`=1, `iload`=32'h2008_0005, `pc_plus_4`=32'h4 → `pc_en`=1 same cycle; next cycle `instr_out`=32'h2008_0005, `pc4_out`=32'h4, `valid_out`=1.
- `stall`=1 with `acc` of 32'hAAAA_0001, hold `stall` 3 cycles → `pc_en` pulses once; `iREN`=0 for 3 cycles; `instr_out` unchanged; one cycle after `stall`=0, `instr_out`=32'hAAAA_0001.
- `flush`=1 coincident with `ihit` of 32'h1234_5678 → `pc_en`=1; next cycle `valid_out`=0 and `instr_out`=`NOP_WORD`.
- `flush` while in BUFFERED → skid discarded; state FETCH; `valid_out`=0; the next `acc` word is delivered normally.
- `dmem_req`=1 for 2 cycles with `ihit` driven → `iREN`=0, `pc_en`=0, IF/ID bubbles; fetch resumes when `dmem_req`=0.
- With `FETCH_HALT_EN`: fetch 32'hFC00_0000 → delivered with valid=1; `halt`=1 the cycle after; `iREN`/`pc_en` stay 0 for 20 cycles despite `ihit`=1. Without the macro: `halt` stays 0 and fetch continues.
